// File: rtl/fport_pkg.sv
// fport_pkg: shared constants and state encoding for the FPort frame decoder
package fport_pkg;
  localparam logic [7:0] DELIM = 8'h7E;
  localparam logic [7:0] ESC = 8'h7D;
  localparam logic [7:0] ESC_XOR = 8'h20;
  localparam logic [7:0] CONTROL_LEN = 8'h19;
  localparam logic [7:0] CONTROL_TYPE = 8'h00;
  localparam int PAYLOAD_BYTES = 22;
  localparam int BODY_BYTES = PAYLOAD_BYTES + 2;
  localparam int PAYLOAD_W = BODY_BYTES * 8;
  localparam int FAILSAFE_BIT = 3;
  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_TYPE,
    ST_BODY,
    ST_CRC,
    ST_END,
    ST_SKIP
  } state_t;
endpackage

// File: rtl/fport_crc_acc.sv
// fport_crc_acc: 8-bit end-around-carry sum over the frame bytes
module fport_crc_acc (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       add,
  input  logic [7:0] data,
  output logic [7:0] sum
);
  logic [7:0] base;
  logic [8:0] raw;
  // clear and add together start a fresh sum with this byte
  always_comb begin
    base = clear ? 8'h00 : sum;
    raw = {1'b0, base} + {1'b0, data};
  end
  // fold the carry out of bit 7 back into the sum
  always_ff @(posedge clock or posedge reset)
    if (reset) sum <= '0;
    else if (add) sum <= raw[7:0] + {7'b0, raw[8]};
    else if (clear) sum <= '0;
endmodule

// File: rtl/fport_frame_decoder.sv
// fport_frame_decoder: unstuffs, checks and unpacks FPort control frames, owns RC failsafe
module fport_frame_decoder
  import fport_pkg::*;
#(
  parameter int NUM_CHANNELS = 16,
  parameter int CHANNEL_BITS = 11,
  parameter int GAP_TIMEOUT = 2000,
  parameter int LINK_TIMEOUT = 1_000_000
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 rxDataReady,
  input  logic [7:0]                           rxData,
  output logic [NUM_CHANNELS*CHANNEL_BITS-1:0] channels,
  output logic [7:0]                           flags,
  output logic [7:0]                           rssi,
  output logic                                 frameValid,
  output logic                                 frameError,
  output logic                                 failsafe
);
  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam int LW = $clog2(LINK_TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TIMEOUT - 1);
  localparam logic [LW-1:0] LINK_MAX = LW'(LINK_TIMEOUT);
  localparam logic [4:0] BODY_LAST = 5'(BODY_BYTES - 1);
  state_t state;
  logic esc;
  logic [4:0] body_cnt;
  logic [8:0] remaining;
  logic [GW-1:0] gap;
  logic [LW-1:0] link_cnt;
  logic [PAYLOAD_W-1:0] payload;
  logic is_delim, is_esc, is_data, running, gap_expired, crc_clear, crc_add;
  logic [7:0] d, sum;
  // classify the incoming byte; escapes are only honoured inside a frame, and END wants a raw delimiter
  always_comb begin
    is_delim = rxDataReady && rxData == DELIM;
    is_esc = rxDataReady && rxData == ESC && !esc && state != ST_HUNT && state != ST_END;
    is_data = rxDataReady && !is_delim && !is_esc;
    d = esc ? rxData ^ ESC_XOR : rxData;
    running = state inside {ST_TYPE, ST_BODY, ST_CRC, ST_END, ST_SKIP};
    gap_expired = !rxDataReady && running && gap == GAP_LAST;
    crc_clear = is_data && state == ST_LEN;
    crc_add = is_data && state inside {ST_LEN, ST_TYPE, ST_BODY};
  end
  fport_crc_acc u_crc (
    .clock(clock),
    .reset(reset),
    .clear(crc_clear),
    .add(crc_add),
    .data(d),
    .sum(sum)
  );
  assign failsafe = link_cnt == LINK_MAX || flags[FAILSAFE_BIT];
  // frame state machine with registered outputs, gap watchdog and link counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_HUNT;
      esc <= 1'b0;
      body_cnt <= '0;
      remaining <= '0;
      gap <= '0;
      link_cnt <= LINK_MAX;
      payload <= '0;
      channels <= '0;
      flags <= '0;
      rssi <= '0;
      frameValid <= 1'b0;
      frameError <= 1'b0;
    end else begin
      frameValid <= 1'b0;
      frameError <= 1'b0;
      link_cnt <= link_cnt == LINK_MAX ? link_cnt : link_cnt + LW'(1);
      gap <= rxDataReady || !running || gap_expired ? '0 : gap + GW'(1);
      if (is_esc) esc <= 1'b1;
      else if (is_delim) begin
        esc <= 1'b0;
        state <= ST_LEN;
        if (!esc && state == ST_END) begin
          channels <= payload[NUM_CHANNELS*CHANNEL_BITS-1:0];
          flags <= payload[PAYLOAD_BYTES*8 +: 8];
          rssi <= payload[(PAYLOAD_BYTES+1)*8 +: 8];
          frameValid <= 1'b1;
          link_cnt <= '0;
        end else frameError <= esc || state inside {ST_TYPE, ST_BODY, ST_CRC};
      end else if (is_data) begin
        esc <= 1'b0;
        case (state)
          ST_LEN: begin
            state <= d == CONTROL_LEN ? ST_TYPE : ST_SKIP;
            remaining <= {1'b0, d} + 9'd1;
          end
          ST_TYPE: begin
            state <= d == CONTROL_TYPE ? ST_BODY : ST_SKIP;
            remaining <= 9'(CONTROL_LEN);
            body_cnt <= '0;
          end
          ST_BODY: begin
            payload <= {d, payload[PAYLOAD_W-1:8]};
            body_cnt <= body_cnt + 5'd1;
            state <= body_cnt == BODY_LAST ? ST_CRC : ST_BODY;
          end
          ST_CRC: begin
            state <= d == ~sum ? ST_END : ST_HUNT;
            frameError <= d != ~sum;
          end
          ST_END: begin
            state <= ST_HUNT;
            frameError <= 1'b1;
          end
          ST_SKIP: begin
            remaining <= remaining - 9'd1;
            state <= remaining == 9'd1 ? ST_HUNT : ST_SKIP;
          end
          default: state <= state;
        endcase
      end else if (gap_expired) begin
        esc <= 1'b0;
        state <= ST_HUNT;
        frameError <= state != ST_SKIP;
      end
    end
  end
endmodule

// File: tb/tb_fport_frame_decoder.sv
// tb_fport_frame_decoder: directed and randomized frame checks against a byte-level model
module tb_fport_frame_decoder;
  localparam int GAP = 200;
  localparam int LINK = 4000;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rxDataReady = 1'b0;
  logic [7:0] rxData = 8'h00;
  logic [175:0] channels;
  logic [7:0] flags, rssi;
  logic frameValid, frameError, failsafe;
  int passed = 0, total = 0, nv = 0, ne = 0, both = 0;
  logic [175:0] exp_ch = '0;
  logic [7:0] exp_fl = '0, exp_rs = '0;
  always #5 clock = ~clock;
  fport_frame_decoder #(.GAP_TIMEOUT(GAP), .LINK_TIMEOUT(LINK)) dut (
    .clock(clock),
    .reset(reset),
    .rxDataReady(rxDataReady),
    .rxData(rxData),
    .channels(channels),
    .flags(flags),
    .rssi(rssi),
    .frameValid(frameValid),
    .frameError(frameError),
    .failsafe(failsafe)
  );
  always @(negedge clock) begin
    if (frameValid) nv++;
    if (frameError) ne++;
    if (frameValid && frameError) both++;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [175:0] obs, input logic [175:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic put(input logic [7:0] b);
    rxData = b;
    rxDataReady = 1'b1;
    @(posedge clock);
    #1;
    rxDataReady = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic put_s(input logic [7:0] b);
    if (b == 8'h7E || b == 8'h7D) begin
      put(8'h7D);
      put(b ^ 8'h20);
    end else put(b);
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  function automatic logic [175:0] rand_ch();
    logic [175:0] v = '0;
    for (int i = 0; i < 16; i++) v[11*i +: 11] = 11'($urandom_range(0, 2047));
    return v;
  endfunction
  function automatic int fold(input int s, input int b);
    return s + b > 255 ? s + b - 255 : s + b;
  endfunction
  function automatic logic [7:0] crc_of(input logic [175:0] ch, input logic [7:0] fl, input logic [7:0] rs);
    int s = 'h19;
    for (int k = 0; k < 22; k++) s = fold(s, int'(ch[8*k +: 8]));
    s = fold(s, int'(fl));
    s = fold(s, int'(rs));
    return 8'(255 - s);
  endfunction
  task automatic send_frame(input logic [175:0] ch, input logic [7:0] fl, input logic [7:0] rs,
                            input logic [7:0] crc_xor, input int body_n);
    logic [7:0] b;
    put(8'h7E);
    put_s(8'h19);
    put_s(8'h00);
    for (int k = 0; k < body_n; k++) begin
      b = k < 22 ? ch[8*k +: 8] : (k == 22 ? fl : rs);
      put_s(b);
    end
    if (body_n == 24) begin
      put_s(crc_of(ch, fl, rs) ^ crc_xor);
      put(8'h7E);
    end
  endtask
  task automatic good_frame(input string tag, input logic [175:0] ch, input logic [7:0] fl, input logic [7:0] rs);
    int v0 = nv, e0 = ne;
    send_frame(ch, fl, rs, 8'h00, 24);
    idle(3);
    exp_ch = ch;
    exp_fl = fl;
    exp_rs = rs;
    check({tag, " channels"}, channels, exp_ch);
    check({tag, " flags"}, flags, exp_fl);
    check({tag, " rssi"}, rssi, exp_rs);
    check({tag, " valid pulses"}, nv - v0, 1);
    check({tag, " error pulses"}, ne - e0, 0);
    check({tag, " failsafe"}, failsafe, exp_fl[3]);
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, " channels"}, channels, 0);
    check({tag, " flags"}, flags, 0);
    check({tag, " rssi"}, rssi, 0);
    check({tag, " frameValid"}, frameValid, 0);
    check({tag, " frameError"}, frameError, 0);
    check({tag, " failsafe"}, failsafe, 1);
  endtask
  initial begin
    logic [175:0] ch;
    int v0, e0;
    idle(3);
    check_reset_vals("reset");
    reset = 1'b0;
    idle(2);
    ch = '0;
    for (int i = 0; i < 16; i++) ch[11*i +: 11] = 11'd992;
    good_frame("center", ch, 8'h00, 8'h64);
    ch = rand_ch();
    ch[8*3 +: 8] = 8'h7E;
    ch[8*7 +: 8] = 8'h7D;
    ch[8*12 +: 8] = 8'h7E;
    good_frame("escaped", ch, 8'h00, 8'h7D);
    for (int n = 0; n < 5; n++) good_frame("random", rand_ch(), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    good_frame("clear flags", rand_ch(), 8'h00, 8'h50);
    v0 = nv;
    e0 = ne;
    send_frame(rand_ch(), 8'h00, 8'h55, 8'h01, 24);
    idle(3);
    check("bad crc error pulses", ne - e0, 1);
    check("bad crc valid pulses", nv - v0, 0);
    check("bad crc channels held", channels, exp_ch);
    check("bad crc rssi held", rssi, exp_rs);
    v0 = nv;
    e0 = ne;
    put(8'h7E);
    put_s(8'h08);
    put_s(8'h01);
    for (int k = 0; k < 7; k++) put_s(8'($urandom_range(0, 255)));
    put_s(8'($urandom_range(0, 255)));
    put(8'h7E);
    idle(3);
    check("downlink error pulses", ne - e0, 0);
    check("downlink valid pulses", nv - v0, 0);
    good_frame("after downlink", rand_ch(), 8'h00, 8'h33);
    v0 = nv;
    e0 = ne;
    send_frame(rand_ch(), 8'h00, 8'h00, 8'h00, 7);
    idle(GAP + 20);
    check("gap error pulses", ne - e0, 1);
    check("gap valid pulses", nv - v0, 0);
    check("gap channels held", channels, exp_ch);
    good_frame("after gap", rand_ch(), 8'h00, 8'h44);
    idle(LINK - 200);
    check("link not yet expired", failsafe, 0);
    idle(400);
    check("link expired failsafe", failsafe, 1);
    good_frame("link restored", rand_ch(), 8'h00, 8'h45);
    good_frame("failsafe flag", rand_ch(), 8'h08, 8'h10);
    good_frame("flag cleared", rand_ch(), 8'h00, 8'h11);
    put(8'h7E);
    put_s(8'h19);
    put_s(8'h00);
    for (int k = 0; k < 5; k++) put_s(8'($urandom_range(0, 255)));
    reset = 1'b1;
    idle(2);
    check_reset_vals("mid-body reset");
    reset = 1'b0;
    exp_ch = '0;
    exp_fl = '0;
    exp_rs = '0;
    good_frame("after reset", rand_ch(), 8'h00, 8'h64);
    check("valid and error together", both, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
